// File: rtl/conv_result_streamer.sv
// Snapshots a ROWSxCOLS signed Conv result frame on out_st and streams it row-major over valid/ready.
// Optional build macro CONV_STREAM_RELU_EN clamps negative elements to zero at the output.
module conv_result_streamer #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 6,
  parameter int unsigned DW   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                out_st,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0]   frame_in,
  input  logic                                m_ready,
  input  logic                                ovf_clr,
  output logic                                m_valid,
  output logic [DW-1:0]                       m_data,
  output logic [2:0]                          m_line,
  output logic [2:0]                          m_row,
  output logic                                m_last,
  output logic                                busy,
  output logic                                ovf,
  output logic [7:0]                          frame_cnt
);

  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;
  localparam logic        FIRST_IS_LAST = (ROWS == 1) && (COLS == 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                             state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]  buf_q;
  logic [IW-1:0]                      line_q, line_d, row_q, row_d;
  logic [IW-1:0]                      nxt_line, nxt_row;
  logic [DW-1:0]                      data_q, data_d;
  logic                               valid_q, valid_d, last_q, last_d;
  logic                               busy_q, busy_d, ovf_q, ovf_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               xfer, capture, drop;

  // Output shaping of one element; indices and handshake are unaffected.
  function automatic logic [DW-1:0] shape(input logic [DW-1:0] e);
`ifdef CONV_STREAM_RELU_EN
    return e[DW-1] ? '0 : e;
`else
    return e;
`endif
  endfunction

  assign xfer    = valid_q & m_ready;
  // A new frame is accepted when idle or exactly as the last beat leaves.
  assign capture = out_st & ((state_q == IDLE) | (xfer & last_q));
  assign drop    = out_st & (state_q == STREAM) & ~(xfer & last_q);

  always_comb begin
    nxt_row  = row_q + IW'(1);
    nxt_line = line_q;
    if (row_q == IW'(COLS - 1)) begin
      nxt_row  = '0;
      nxt_line = line_q + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    case (state_q)
      IDLE: ;
      STREAM: begin
        if (xfer) begin
          if (last_q) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            line_d  = '0;
            row_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            line_d = nxt_line;
            row_d  = nxt_row;
            data_d = shape(buf_q[nxt_line][nxt_row]);
            last_d = (nxt_line == IW'(ROWS - 1)) && (nxt_row == IW'(COLS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // First beat comes straight from frame_in so there is no bubble.
    if (capture) begin
      state_d = STREAM;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      line_d  = '0;
      row_d   = '0;
      data_d  = shape(frame_in[0][0]);
      last_d  = FIRST_IS_LAST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame buffer needs no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= frame_in;
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_line    = line_q;
  assign m_row     = row_q;
  assign m_last    = last_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: streaming, stalls, drops, back-to-back frames, mid-stream reset.
module tb_conv_result_streamer;

  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int DW   = 16;
  localparam int NB   = ROWS * COLS;

  logic                               clk = 1'b0;
  logic                               reset;
  logic                               out_st;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]  frame_in;
  logic                               m_ready;
  logic                               ovf_clr;
  logic                               m_valid;
  logic [DW-1:0]                      m_data;
  logic [2:0]                         m_line;
  logic [2:0]                         m_row;
  logic                               m_last;
  logic                               busy;
  logic                               ovf;
  logic [7:0]                         frame_cnt;

  int total = 0;
  int bad   = 0;

  conv_result_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .reset(reset), .out_st(out_st), .frame_in(frame_in),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .m_valid(m_valid), .m_data(m_data),
    .m_line(m_line), .m_row(m_row), .m_last(m_last), .busy(busy), .ovf(ovf),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Element k of a frame filled with base+index, after optional ReLU.
  function automatic int exp_val(input int base, input int k);
    int v;
    v = base + k;
`ifdef CONV_STREAM_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic load_frame(input int base);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        frame_in[i][j] = 16'(base + i * COLS + j);
  endtask

  task automatic test_reset();
    total++;
    if ({m_valid, m_data, m_line, m_row, m_last, busy, ovf, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%0d l=%0d r=%0d last=%b busy=%b ovf=%b cnt=%0d exp all 0",
               m_valid, m_data, m_line, m_row, m_last, busy, ovf, frame_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int v;
    load_frame(-18);
    m_ready = 1'b1;
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    for (int k = 0; k < NB; k++) begin
      v = exp_val(-18, k);
      total++;
      if ({m_valid, busy, m_data, m_line, m_row, m_last} !==
          {1'b1, 1'b1, 16'(v), 3'(k / COLS), 3'(k % COLS), 1'(k == NB - 1)}) begin
        bad++;
        $display("FAIL stream beat%0d got v=%b d=%0d l=%0d r=%0d last=%b exp d=%0d",
                 k, m_valid, $signed(m_data), m_line, m_row, m_last, v);
      end
      @(negedge clk);
    end
    total++;
    if ({m_valid, busy, frame_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL stream_end got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=1", m_valid, busy, frame_cnt);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int cyc = 0;
    int v;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    load_frame(-3);
    m_ready = 1'b0;
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    while (k < NB && cyc < 400) begin
      v = exp_val(-3, k);
      total++;
      if ({m_valid, m_data, m_line, m_row, m_last} !==
          {1'b1, 16'(v), 3'(k / COLS), 3'(k % COLS), 1'(k == NB - 1)}) begin
        bad++;
        $display("FAIL stall beat%0d cyc%0d got v=%b d=%0d l=%0d r=%0d last=%b exp d=%0d",
                 k, cyc, m_valid, $signed(m_data), m_line, m_row, m_last, v);
      end
      m_ready = pat[cyc % 4];
      @(negedge clk);
      if (m_ready) k++;
      cyc++;
    end
    m_ready = 1'b0;
    total++;
    if (k != NB) begin
      bad++;
      $display("FAIL stall_timeout got beats=%0d exp %0d", k, NB);
    end
    total++;
    if ({m_valid, busy, frame_cnt} !== {1'b0, 1'b0, 8'd2}) begin
      bad++;
      $display("FAIL stall_end got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=2", m_valid, busy, frame_cnt);
    end
  endtask

  task automatic test_overflow();
    int v;
    load_frame(50);
    m_ready = 1'b1;
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    for (int k = 0; k < NB; k++) begin
      v = exp_val(50, k);
      total++;
      if ({m_valid, m_data, m_line, m_row, m_last} !==
          {1'b1, 16'(v), 3'(k / COLS), 3'(k % COLS), 1'(k == NB - 1)}) begin
        bad++;
        $display("FAIL ovf_stream beat%0d got v=%b d=%0d l=%0d r=%0d last=%b exp d=%0d",
                 k, m_valid, $signed(m_data), m_line, m_row, m_last, v);
      end
      if (k == 5) load_frame(900);
      out_st  = (k == 5) || (k == 15);
      ovf_clr = (k == 10) || (k == 15);
      @(negedge clk);
      out_st  = 1'b0;
      ovf_clr = 1'b0;
      if (k == 5 || k == 10 || k == 15) begin
        total++;
        if (ovf !== 1'(k != 10)) begin
          bad++;
          $display("FAIL ovf_flag after beat%0d got %b exp %b", k, ovf, 1'(k != 10));
        end
      end
    end
    total++;
    if ({m_valid, frame_cnt, ovf} !== {1'b0, 8'd3, 1'b1}) begin
      bad++;
      $display("FAIL ovf_end got v=%b cnt=%0d ovf=%b exp v=0 cnt=3 ovf=1", m_valid, frame_cnt, ovf);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got %b exp 0", ovf);
    end
  endtask

  task automatic test_back_to_back();
    int v;
    load_frame(-18);
    m_ready = 1'b1;
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    for (int k = 0; k < NB; k++) begin
      v = exp_val(-18, k);
      total++;
      if ({m_valid, m_data, m_line, m_row, m_last} !==
          {1'b1, 16'(v), 3'(k / COLS), 3'(k % COLS), 1'(k == NB - 1)}) begin
        bad++;
        $display("FAIL b2b_f1 beat%0d got v=%b d=%0d l=%0d r=%0d last=%b exp d=%0d",
                 k, m_valid, $signed(m_data), m_line, m_row, m_last, v);
      end
      if (k == NB - 1) begin
        load_frame(200);
        out_st = 1'b1;
      end
      @(negedge clk);
      out_st = 1'b0;
    end
    total++;
    if ({frame_cnt, ovf} !== {8'd4, 1'b0}) begin
      bad++;
      $display("FAIL b2b_cnt1 got cnt=%0d ovf=%b exp cnt=4 ovf=0", frame_cnt, ovf);
    end
    for (int k = 0; k < NB; k++) begin
      v = exp_val(200, k);
      total++;
      if ({m_valid, m_data, m_line, m_row, m_last} !==
          {1'b1, 16'(v), 3'(k / COLS), 3'(k % COLS), 1'(k == NB - 1)}) begin
        bad++;
        $display("FAIL b2b_f2 beat%0d got v=%b d=%0d l=%0d r=%0d last=%b exp d=%0d",
                 k, m_valid, $signed(m_data), m_line, m_row, m_last, v);
      end
      @(negedge clk);
    end
    total++;
    if ({m_valid, busy, frame_cnt} !== {1'b0, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL b2b_end got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=5", m_valid, busy, frame_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    load_frame(-18);
    m_ready = 1'b1;
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({m_valid, m_line, m_row} !== {1'b1, 3'd1, 3'd4}) begin
      bad++;
      $display("FAIL midreset_pre got v=%b l=%0d r=%0d exp v=1 l=1 r=4", m_valid, m_line, m_row);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({m_valid, m_data, m_line, m_row, m_last, busy, ovf, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_async got v=%b d=%0d l=%0d r=%0d last=%b busy=%b cnt=%0d exp all 0",
               m_valid, m_data, m_line, m_row, m_last, busy, frame_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({m_valid, busy, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_idle got v=%b busy=%b cnt=%0d exp all 0", m_valid, busy, frame_cnt);
    end
    load_frame(7);
    out_st = 1'b1;
    @(negedge clk);
    out_st = 1'b0;
    total++;
    if ({m_valid, busy, m_data, m_line, m_row, m_last} !== {1'b1, 1'b1, 16'd7, 3'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_restart got v=%b d=%0d l=%0d r=%0d last=%b exp v=1 d=7 l=0 r=0",
               m_valid, $signed(m_data), m_line, m_row, m_last);
    end
  endtask

  initial begin
    reset    = 1'b0;
    out_st   = 1'b0;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    frame_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
